mem_access_stage: RTL and testbench

- Memory-access stage of the pipelined processor. Sits between the EX/MEM segment register (upstream) and the MEM/WB segment register (downstream).
- Performs load and store accesses to a data memory that answers with a variable-latency req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Presents writeback control, ALU result, load data and destination register to MEM/WB.

---
 rtl/mem_access_if.sv | 25 ++
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage and the data memory.
//   master : stage side. Drives dmem_req/dmem_we/dmem_addr/dmem_wdata and
//            receives dmem_rdata/dmem_ack.
//   slave  : memory side, with the opposite directions.
// dmem_ack is a single-cycle pulse; dmem_rdata is valid only while it is high.
interface mem_access_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the pipelined processor, between the EX/MEM and
// MEM/WB segment registers. Loads and stores go to a variable-latency data
// memory through a req/ack handshake. Upstream is stalled while an access is
// in flight, and a hung access is abandoned after TIMEOUT cycles.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   valid_in          EX/MEM holds a valid instruction
//   MemRead_in        load
//   MemWrite_in       store (a store wins when both are set)
//   MemToReg_in       writeback selects memory data (passed through)
//   RegWrite_in       instruction writes the register file
//   alu_in            ALU result / memory address
//   store_in          store data
//   RR3_in            destination register (passed through)
//   stall             hold EX/MEM and earlier stages
//   dmem              data-memory bus (master side)
//   MemToReg_out, RegWrite_out, mem_out, alu_out, RR3_out   to MEM/WB
//   err               sticky: some access timed out since reset
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic [REG_W-1:0]  RR3_in,
  output logic              stall,
  mem_access_if.master      dmem,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  RR3_out,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [CNT_W-1:0]  cnt_p0;
  logic [DATA_W-1:0] req_addr_p0;
  logic [DATA_W-1:0] req_wdata_p0;
  logic              req_we_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;

  logic acc;
  logic timeout;

  assign acc     = valid_in & (MemRead_in | MemWrite_in);
  // Ack has priority: a timeout is only declared on a cycle without ack.
  assign timeout = (cnt_p0 == CNT_LAST) & ~dmem.dmem_ack;

  assign alu_out      = alu_in;
  assign RR3_out      = RR3_in;
  assign MemToReg_out = MemToReg_in;

  // The request is driven from the captured copy so it stays stable even if
  // the upstream inputs move during the access.
  assign dmem.dmem_addr  = req_addr_p0;
  assign dmem.dmem_wdata = req_wdata_p0;
  assign dmem.dmem_we    = req_we_p0;
  assign err             = err_p1;

  always_comb begin
    state_nxt     = state_p0;
    stall         = 1'b0;
    dmem.dmem_req = 1'b0;
    RegWrite_out  = 1'b0;
    mem_out       = '0;
    if (!rst) begin
      case (state_p0)
        IDLE: begin
          if (acc) begin
            stall     = 1'b1;
            state_nxt = ACCESS;
          end else begin
            RegWrite_out = RegWrite_in & valid_in;
          end
        end
        ACCESS: begin
          dmem.dmem_req = 1'b1;
          stall         = 1'b1;
          if (dmem.dmem_ack || timeout) state_nxt = DONE;
        end
        DONE: begin
          mem_out      = rdata_p1;
          RegWrite_out = RegWrite_in & valid_in;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request capture (IDLE -> ACCESS)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= IDLE;
      cnt_p0       <= '0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_we_p0    <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      case (state_p0)
        IDLE: begin
          if (acc) begin
            req_addr_p0  <= alu_in;
            req_wdata_p0 <= store_in;
            req_we_p0    <= MemWrite_in;
            cnt_p0       <= '0;
          end
        end
        ACCESS:  cnt_p0 <= cnt_p0 + 1'b1;
        default: ;
      endcase
    end
  end

  // Response capture (ACCESS -> DONE)
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (state_p0 == ACCESS) begin
      if (dmem.dmem_ack) begin
        if (!req_we_p0) rdata_p1 <= dmem.dmem_rdata;
      end else if (timeout) begin
        rdata_p1 <= '0;
        err_p1   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in, MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
  logic [DATA_W-1:0] alu_in, store_in;
  logic [REG_W-1:0]  RR3_in;
  logic              stall, MemToReg_out, RegWrite_out, err;
  logic [DATA_W-1:0] mem_out, alu_out;
  logic [REG_W-1:0]  RR3_out;

  mem_access_if #(.DATA_W(DATA_W)) dmem_bus ();

  mem_access_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .MemToReg_in  (MemToReg_in),
    .RegWrite_in  (RegWrite_in),
    .alu_in       (alu_in),
    .store_in     (store_in),
    .RR3_in       (RR3_in),
    .stall        (stall),
    .dmem         (dmem_bus),
    .MemToReg_out (MemToReg_out),
    .RegWrite_out (RegWrite_out),
    .mem_out      (mem_out),
    .alu_out      (alu_out),
    .RR3_out      (RR3_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: last load result kept for MEM/WB and the sticky error.
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Non-memory instruction, issued while the stage is idle.
  task automatic do_op(input bit v, input bit rd, input bit wr, input bit m2r, input bit rw,
                       input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] rr,
                       input bit exp_rw);
    @(negedge clk);
    valid_in = v; MemRead_in = rd; MemWrite_in = wr; MemToReg_in = m2r; RegWrite_in = rw;
    alu_in = alu; store_in = $urandom; RR3_in = rr;
    dmem_bus.dmem_ack = 1'($urandom); dmem_bus.dmem_rdata = $urandom;
    #2;
    check("nonmem", {stall, dmem_bus.dmem_req, RegWrite_out, MemToReg_out, err, mem_out, alu_out, RR3_out},
                    {1'b0, 1'b0, exp_rw, m2r, m_err, 32'h0, alu, rr});
  endtask

  // Memory instruction. ack_at in 1..TIMEOUT = ACCESS cycle carrying the ack;
  // anything else means the memory never answers.
  task automatic do_mem(input bit rd, input bit wr, input bit m2r, input bit rw,
                        input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input logic [REG_W-1:0] rr, input int ack_at,
                        input logic [DATA_W-1:0] rdata);
    bit acked;
    int n_acc;
    logic [DATA_W-1:0] exp_mem;
    acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
    n_acc = acked ? ack_at : TIMEOUT;
    @(negedge clk);
    valid_in = 1'b1; MemRead_in = rd; MemWrite_in = wr; MemToReg_in = m2r; RegWrite_in = rw;
    alu_in = addr; store_in = wdata; RR3_in = rr; dmem_bus.dmem_ack = 1'b0;
    #2;
    check("issue", {stall, dmem_bus.dmem_req, RegWrite_out}, {1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= n_acc; k++) begin
      @(negedge clk);
      alu_in = $urandom; store_in = $urandom;
      dmem_bus.dmem_ack   = acked && (k == ack_at);
      dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? rdata : $urandom;
      #2;
      check("access", {stall, dmem_bus.dmem_req, RegWrite_out, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata},
                      {1'b1, 1'b1, 1'b0, wr, addr, wdata});
    end
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0; alu_in = addr; store_in = wdata;
    if (!acked)  exp_mem = '0;
    else if (wr) exp_mem = m_rdata;
    else         exp_mem = rdata;
    m_rdata = exp_mem;
    m_err   = m_err | !acked;
    #2;
    check("done", {stall, dmem_bus.dmem_req, RegWrite_out, err, mem_out, alu_out, RR3_out},
                  {1'b0, 1'b0, rw, m_err, exp_mem, addr, rr});
    // Stray ack in DONE must not disturb anything.
    dmem_bus.dmem_ack = 1'($urandom); dmem_bus.dmem_rdata = $urandom;
  endtask

  typedef struct {
    bit v, rd, wr, m2r, rw;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rr;
    bit exp_rw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 0, 0, 0, 1, 32'h0000_0005, 4'd3, 1};
    vecs[1] = '{1, 0, 0, 1, 0, 32'hFFFF_FFFF, 4'd15, 0};
    vecs[2] = '{0, 0, 0, 0, 1, 32'h1234_0000, 4'd7, 0};
    vecs[3] = '{0, 1, 0, 1, 1, 32'h0000_0040, 4'd1, 0};
    vecs[4] = '{0, 0, 1, 0, 1, 32'h8000_0000, 4'd9, 0};
    vecs[5] = '{1, 0, 0, 1, 1, 32'hA5A5_5A5A, 4'd0, 1};

    // Reset with a load presented: outputs forced idle.
    rst = 1'b1; valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
    MemToReg_in = 1'b1; RegWrite_in = 1'b1; alu_in = 32'h40; store_in = '0; RR3_in = '0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    m_rdata = '0; m_err = 1'b0;
    #2;
    check("rst_forced0", {stall, dmem_bus.dmem_req, RegWrite_out}, 3'b000);
    @(negedge clk); @(negedge clk);
    #2;
    check("rst_forced1", {stall, dmem_bus.dmem_req, RegWrite_out}, 3'b000);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; MemRead_in = 1'b0;
    #2;
    check("post_rst", {stall, dmem_bus.dmem_req, err, mem_out}, 35'h0);

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].rw, vecs[i].alu, vecs[i].rr, vecs[i].exp_rw);

    do_mem(1, 0, 1, 1, 32'h40, 32'h0, 4'd5, 3, 32'hCAFE_F00D);        // load, ack after 3
    do_mem(0, 1, 0, 0, 32'h80, 32'h1234_5678, 4'd0, 1, 32'h0);        // store, immediate ack
    do_mem(1, 1, 0, 0, 32'h84, 32'h0BAD_0BAD, 4'd2, 2, 32'h1111_2222); // both set: store
    do_mem(1, 0, 1, 1, 32'h104, 32'h0, 4'd6, TIMEOUT, 32'hA5A5_A5A5); // ack on last cycle
    do_mem(1, 0, 1, 1, 32'h100, 32'h0, 4'd4, 0, 32'h0);               // timeout
    do_op(1, 0, 0, 0, 1, 32'h77, 4'd2, 1);                             // err stays set

    for (int i = 0; i < 40; i++) begin
      int kind, r, ack_at;
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      ack_at = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 4);
      if (kind == 0) begin
        bit v, rw;
        v = 1'($urandom); rw = 1'($urandom);
        if (v) do_op(1, 0, 0, 1'($urandom), rw, $urandom, 4'($urandom), rw);
        else   do_op(0, 1'($urandom), 1'($urandom), 1'($urandom), rw, $urandom, 4'($urandom), 0);
      end else begin
        do_mem(kind != 2, kind != 1, 1'($urandom), 1'($urandom), $urandom, $urandom,
               4'($urandom), ack_at, $urandom);
      end
    end

    // Reset on the 2nd ACCESS cycle, then a late ack.
    @(negedge clk);
    valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1;
    alu_in = 32'h200; dmem_bus.dmem_ack = 1'b0;
    #2;
    check("err_before_rst", err, m_err);
    @(negedge clk);
    #2;
    check("rst_seq_access1", dmem_bus.dmem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_seq_forced", {stall, dmem_bus.dmem_req, RegWrite_out}, 3'b000);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; MemRead_in = 1'b0;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    m_err = 1'b0; m_rdata = '0;
    #2;
    check("rst_seq_idle", {stall, dmem_bus.dmem_req, err, mem_out}, 35'h0);
    do_mem(0, 1, 0, 0, 32'h300, 32'h5555_AAAA, 4'd1, 1, 32'h0);        // store shows zeroed rdata
    do_mem(1, 0, 1, 1, 32'h204, 32'h0, 4'd8, 2, 32'h1357_9BDF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
